control_sequencer: RTL and testbench

- Moore-style control unit that drives every datapath strobe of the single-bus processor (PC, IR, MAR, MDR, Y, Z, register-select, ALU-op, CON, memory).
- Sequences fetch (T0-T2) and execute (T3-T7) for a fixed instruction subset.
- Stretches memory steps with a ready handshake.
- Replaces the hand-driven strobe sequences used in the processor benches today.

---
 rtl/control_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : control_sequencer                                          |
// | Description : Moore-style control unit for the single-bus processor.     |
// |               Sequences fetch (T0-T2) and execute (T3-T7) for the        |
// |               supported instruction subset, stretching memory steps      |
// |               until mem_done.                                            |
// | Options     : STEP_MODE_EN - adds a STEP_WAIT state at every             |
// |               instruction boundary, released by a step pulse.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module control_sequencer #(
    parameter logic [4:0] OP_LD   = 5'd0,
    parameter logic [4:0] OP_LDI  = 5'd1,
    parameter logic [4:0] OP_ST   = 5'd2,
    parameter logic [4:0] OP_ADD  = 5'd3,
    parameter logic [4:0] OP_SUB  = 5'd4,
    parameter logic [4:0] OP_AND  = 5'd5,
    parameter logic [4:0] OP_OR   = 5'd6,
    parameter logic [4:0] OP_ADDI = 5'd12,
    parameter logic [4:0] OP_BR   = 5'd18,
    parameter logic [4:0] OP_NOP  = 5'd26,
    parameter logic [4:0] OP_HALT = 5'd27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_done,
    input  logic        stop,
    input  logic        step,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Cout,
    output logic        BAout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        CONin,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        Read,
    output logic        Write,
    output logic        run,
    output logic        illegal
);

    // Each ALU op gets its own T4 state so the one-hot op strobe is a pure
    // function of state; LD and ST keep separate T4/T5 states so the T5 exit
    // does not need to re-decode the IR.
    typedef enum logic [4:0] {
        S_RESET   = 5'd0,
        S_T0      = 5'd1,
        S_T1      = 5'd2,
        S_T1W     = 5'd3,
        S_T2      = 5'd4,
        S_T3      = 5'd5,
        S_ADD_T4  = 5'd6,
        S_SUB_T4  = 5'd7,
        S_AND_T4  = 5'd8,
        S_OR_T4   = 5'd9,
        S_ALU_T5  = 5'd10,
        S_IMM_T4  = 5'd11,
        S_IMM_T5  = 5'd12,
        S_LD_T4   = 5'd13,
        S_LD_T5   = 5'd14,
        S_LD_T6   = 5'd15,
        S_LD_T7   = 5'd16,
        S_ST_T4   = 5'd17,
        S_ST_T5   = 5'd18,
        S_ST_T6   = 5'd19,
        S_ST_T7   = 5'd20,
        S_BR_T4   = 5'd21,
        S_BR_T5   = 5'd22,
        S_BR_T6   = 5'd23,
`ifdef STEP_MODE_EN
        S_STEP_WAIT = 5'd25,
`endif
        S_HALT    = 5'd24
    } state_t;

    state_t      r_state;
    state_t      w_next;
    state_t      w_boundary;
    logic [4:0]  w_opcode;
    logic        w_opcode_legal;

    assign w_opcode = ir[31:27];

    // Only the opcode field steers sequencing; operand fields belong to the datapath.
`ifdef STEP_MODE_EN
    logic [26:0] w_unused_ir;
    assign w_unused_ir = ir[26:0];
`else
    logic [27:0] w_unused_in;
    assign w_unused_in = {step, ir[26:0]};
`endif

    // Any opcode outside the supported set executes as a NOP and flags illegal.
    always_comb begin
        w_opcode_legal = 1'b0;
        case (w_opcode)
            OP_LD, OP_LDI, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_BR, OP_NOP, OP_HALT: w_opcode_legal = 1'b1;
            default:                          w_opcode_legal = 1'b0;
        endcase
    end

    // Destination taken when an instruction retires: halt requests win.
    always_comb begin
`ifdef STEP_MODE_EN
        w_boundary = stop ? S_HALT : S_STEP_WAIT;
`else
        w_boundary = stop ? S_HALT : S_T0;
`endif
    end

    // State register; reset abandons any instruction or memory wait in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RESET;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state sequencing; mem_done only matters in the four memory states.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_RESET:  w_next = S_T0;
            S_T0:     w_next = S_T1;
            S_T1:     w_next = mem_done ? S_T2 : S_T1W;
            S_T1W:    w_next = mem_done ? S_T2 : S_T1W;
            S_T2:     w_next = S_T3;
            S_T3: begin
                case (w_opcode)
                    OP_ADD:          w_next = S_ADD_T4;
                    OP_SUB:          w_next = S_SUB_T4;
                    OP_AND:          w_next = S_AND_T4;
                    OP_OR:           w_next = S_OR_T4;
                    OP_ADDI, OP_LDI: w_next = S_IMM_T4;
                    OP_LD:           w_next = S_LD_T4;
                    OP_ST:           w_next = S_ST_T4;
                    OP_BR:           w_next = S_BR_T4;
                    OP_HALT:         w_next = S_HALT;
                    default:         w_next = w_boundary;
                endcase
            end
            S_ADD_T4, S_SUB_T4, S_AND_T4, S_OR_T4: w_next = S_ALU_T5;
            S_ALU_T5: w_next = w_boundary;
            S_IMM_T4: w_next = S_IMM_T5;
            S_IMM_T5: w_next = w_boundary;
            S_LD_T4:  w_next = S_LD_T5;
            S_LD_T5:  w_next = S_LD_T6;
            S_LD_T6:  w_next = mem_done ? S_LD_T7 : S_LD_T6;
            S_LD_T7:  w_next = w_boundary;
            S_ST_T4:  w_next = S_ST_T5;
            S_ST_T5:  w_next = S_ST_T6;
            S_ST_T6:  w_next = S_ST_T7;
            S_ST_T7:  w_next = mem_done ? w_boundary : S_ST_T7;
            S_BR_T4:  w_next = S_BR_T5;
            S_BR_T5:  w_next = S_BR_T6;
            S_BR_T6:  w_next = w_boundary;
            S_HALT:   w_next = S_HALT;
`ifdef STEP_MODE_EN
            S_STEP_WAIT: begin
                if (stop) begin
                    w_next = S_HALT;
                end else if (step) begin
                    w_next = S_T0;
                end else begin
                    w_next = S_STEP_WAIT;
                end
            end
`endif
            default:  w_next = S_RESET;
        endcase
    end

    // Strobe decode from the current state (T3 also looks at the opcode).
    always_comb begin
        PCout   = 1'b0;
        PCin    = 1'b0;
        IncPC   = 1'b0;
        MARin   = 1'b0;
        MDRin   = 1'b0;
        MDRout  = 1'b0;
        IRin    = 1'b0;
        Yin     = 1'b0;
        Zin     = 1'b0;
        Zlowout = 1'b0;
        Cout    = 1'b0;
        BAout   = 1'b0;
        Gra     = 1'b0;
        Grb     = 1'b0;
        Grc     = 1'b0;
        Rin     = 1'b0;
        Rout    = 1'b0;
        CONin   = 1'b0;
        ADD     = 1'b0;
        SUB     = 1'b0;
        AND     = 1'b0;
        OR      = 1'b0;
        Read    = 1'b0;
        Write   = 1'b0;
        illegal = 1'b0;
        run     = 1'b1;
        case (r_state)
            S_RESET, S_HALT: run = 1'b0;
`ifdef STEP_MODE_EN
            S_STEP_WAIT:     run = 1'b0;
`endif
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T1W, S_LD_T6: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                case (w_opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI: begin
                        Grb  = 1'b1;
                        Rout = 1'b1;
                        Yin  = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        Grb   = 1'b1;
                        BAout = 1'b1;
                        Yin   = 1'b1;
                    end
                    OP_BR: begin
                        Gra   = 1'b1;
                        Rout  = 1'b1;
                        CONin = 1'b1;
                    end
                    default: illegal = ~w_opcode_legal;
                endcase
            end
            S_ADD_T4, S_SUB_T4, S_AND_T4, S_OR_T4: begin
                Grc  = 1'b1;
                Rout = 1'b1;
                Zin  = 1'b1;
                ADD  = (r_state == S_ADD_T4);
                SUB  = (r_state == S_SUB_T4);
                AND  = (r_state == S_AND_T4);
                OR   = (r_state == S_OR_T4);
            end
            S_IMM_T4, S_LD_T4, S_ST_T4, S_BR_T5: begin
                Cout = 1'b1;
                ADD  = 1'b1;
                Zin  = 1'b1;
            end
            S_ALU_T5, S_IMM_T5: begin
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
            end
            S_LD_T5, S_ST_T5: begin
                Zlowout = 1'b1;
                MARin   = 1'b1;
            end
            S_LD_T7: begin
                MDRout = 1'b1;
                Gra    = 1'b1;
                Rin    = 1'b1;
            end
            S_ST_T6: begin
                Gra   = 1'b1;
                Rout  = 1'b1;
                MDRin = 1'b1;
            end
            S_ST_T7: Write = 1'b1;
            S_BR_T4: begin
                PCout = 1'b1;
                Yin   = 1'b1;
            end
            S_BR_T6: begin
                Zlowout = 1'b1;
                PCin    = con_ff;
            end
            default: run = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_control_sequencer                                       |
// | Description : Directed bench for control_sequencer. The driver pushes    |
// |               the expected strobe word for each cycle into a queue; a    |
// |               negedge monitor pops and compares against the DUT.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_control_sequencer;

    // Strobe word bit order matches the concatenation in the monitor.
    localparam logic [25:0] c_PCOUT   = 26'd1 << 25;
    localparam logic [25:0] c_PCIN    = 26'd1 << 24;
    localparam logic [25:0] c_INCPC   = 26'd1 << 23;
    localparam logic [25:0] c_MARIN   = 26'd1 << 22;
    localparam logic [25:0] c_MDRIN   = 26'd1 << 21;
    localparam logic [25:0] c_MDROUT  = 26'd1 << 20;
    localparam logic [25:0] c_IRIN    = 26'd1 << 19;
    localparam logic [25:0] c_YIN     = 26'd1 << 18;
    localparam logic [25:0] c_ZIN     = 26'd1 << 17;
    localparam logic [25:0] c_ZLOW    = 26'd1 << 16;
    localparam logic [25:0] c_COUT    = 26'd1 << 15;
    localparam logic [25:0] c_BAOUT   = 26'd1 << 14;
    localparam logic [25:0] c_GRA     = 26'd1 << 13;
    localparam logic [25:0] c_GRB     = 26'd1 << 12;
    localparam logic [25:0] c_GRC     = 26'd1 << 11;
    localparam logic [25:0] c_RIN     = 26'd1 << 10;
    localparam logic [25:0] c_ROUT    = 26'd1 << 9;
    localparam logic [25:0] c_CONIN   = 26'd1 << 8;
    localparam logic [25:0] c_ADD     = 26'd1 << 7;
    localparam logic [25:0] c_SUB     = 26'd1 << 6;
    localparam logic [25:0] c_AND     = 26'd1 << 5;
    localparam logic [25:0] c_OR      = 26'd1 << 4;
    localparam logic [25:0] c_READ    = 26'd1 << 3;
    localparam logic [25:0] c_WRITE   = 26'd1 << 2;
    localparam logic [25:0] c_RUN     = 26'd1 << 1;
    localparam logic [25:0] c_ILL     = 26'd1 << 0;

    // Hand-built expected strobe words per step.
    localparam logic [25:0] c_E_T0   = c_PCOUT | c_MARIN | c_INCPC | c_ZIN | c_RUN;
    localparam logic [25:0] c_E_T1   = c_ZLOW | c_PCIN | c_READ | c_MDRIN | c_RUN;
    localparam logic [25:0] c_E_T1W  = c_READ | c_MDRIN | c_RUN;
    localparam logic [25:0] c_E_T2   = c_MDROUT | c_IRIN | c_RUN;
    localparam logic [25:0] c_E_RT3  = c_GRB | c_ROUT | c_YIN | c_RUN;
    localparam logic [25:0] c_E_BT3  = c_GRB | c_BAOUT | c_YIN | c_RUN;
    localparam logic [25:0] c_E_RT4  = c_GRC | c_ROUT | c_ZIN | c_RUN;
    localparam logic [25:0] c_E_CT4  = c_COUT | c_ADD | c_ZIN | c_RUN;
    localparam logic [25:0] c_E_WB   = c_ZLOW | c_GRA | c_RIN | c_RUN;
    localparam logic [25:0] c_E_MT5  = c_ZLOW | c_MARIN | c_RUN;
    localparam logic [25:0] c_E_LD6  = c_READ | c_MDRIN | c_RUN;
    localparam logic [25:0] c_E_LD7  = c_MDROUT | c_GRA | c_RIN | c_RUN;
    localparam logic [25:0] c_E_ST6  = c_GRA | c_ROUT | c_MDRIN | c_RUN;
    localparam logic [25:0] c_E_ST7  = c_WRITE | c_RUN;
    localparam logic [25:0] c_E_BRT3 = c_GRA | c_ROUT | c_CONIN | c_RUN;
    localparam logic [25:0] c_E_BRT4 = c_PCOUT | c_YIN | c_RUN;
    localparam logic [25:0] c_E_BRT6 = c_ZLOW | c_RUN;
    localparam logic [25:0] c_E_IDLE = 26'd0;

    typedef struct {
        logic [25:0] exp;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] ir;
    logic        con_ff;
    logic        mem_done;
    logic        stop;
    logic        step;
    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout, BAout;
    logic Gra, Grb, Grc, Rin, Rout, CONin, ADD, SUB, AND, OR, Read, Write, run, illegal;

    exp_t        q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    control_sequencer dut (
        .clk(clk), .reset(reset), .ir(ir), .con_ff(con_ff), .mem_done(mem_done),
        .stop(stop), .step(step),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
        .Cout(Cout), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin),
        .Rout(Rout), .CONin(CONin), .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
        .Read(Read), .Write(Write), .run(run), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compare the live strobe word against the queued expectation.
    always begin
        @(negedge clk);
        if (q.size() != 0) begin
            exp_t        item;
            logic [25:0] act;
            item = q.pop_front();
            act = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                   Cout, BAout, Gra, Grb, Grc, Rin, Rout, CONin, ADD, SUB, AND, OR,
                   Read, Write, run, illegal};
            n_total++;
            if (act === item.exp) begin
                n_pass++;
            end else begin
                $display("FAIL %s: strobes got %h expected %h (t=%0t)",
                         item.name, act, item.exp, $time);
            end
        end
    end

    // Queue this cycle's expectation, then advance one clock.
    task automatic chk(input logic [25:0] e, input string nm);
        q.push_back('{exp: e, name: nm});
        @(posedge clk);
        #1;
    endtask

    // Three fetch cycles with an immediately ready memory.
    task automatic fetch(input logic [4:0] op, input string nm);
        ir = {op, 27'd35};
        mem_done = 1'b1;
        chk(c_E_T0, {nm, "_t0"});
        chk(c_E_T1, {nm, "_t1"});
        chk(c_E_T2, {nm, "_t2"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout required completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; ir = 32'd0; con_ff = 1'b0; mem_done = 1'b1; stop = 1'b0; step = 1'b0;
        @(posedge clk);
        #1;
        chk(c_E_IDLE, "reset_hold");
        reset = 1'b0;
        chk(c_E_IDLE, "reset_exit");

        // addi with memory always ready: T0..T5 in six cycles
        fetch(5'd12, "addi");
        chk(c_E_RT3, "addi_t3");
        chk(c_E_CT4, "addi_t4");
        chk(c_E_WB,  "addi_t5");

        // br taken then not taken
        con_ff = 1'b1;
        fetch(5'd18, "br1");
        chk(c_E_BRT3, "br1_t3");
        chk(c_E_BRT4, "br1_t4");
        chk(c_E_CT4,  "br1_t5");
        chk(c_E_BRT6 | c_PCIN, "br1_t6_taken");
        con_ff = 1'b0;
        fetch(5'd18, "br0");
        chk(c_E_BRT3, "br0_t3");
        chk(c_E_BRT4, "br0_t4");
        con_ff = 1'b1;
        chk(c_E_CT4,  "br0_t5");
        con_ff = 1'b0;
        chk(c_E_BRT6, "br0_t6_not_taken");

        // ld with stretched fetch and stretched data read
        ir = {5'd0, 27'd4};
        mem_done = 1'b1;
        chk(c_E_T0, "ld_t0");
        mem_done = 1'b0;
        chk(c_E_T1,  "ld_t1");
        chk(c_E_T1W, "ld_t1w_a");
        mem_done = 1'b1;
        chk(c_E_T1W, "ld_t1w_done");
        chk(c_E_T2,  "ld_t2");
        chk(c_E_BT3, "ld_t3");
        chk(c_E_CT4, "ld_t4");
        chk(c_E_MT5, "ld_t5");
        mem_done = 1'b0;
        chk(c_E_LD6, "ld_t6_a");
        chk(c_E_LD6, "ld_t6_b");
        mem_done = 1'b1;
        chk(c_E_LD6, "ld_t6_done");
        mem_done = 1'b0;
        chk(c_E_LD7, "ld_t7");

        // st: mem_done in T6 is ignored, Write held until mem_done
        fetch(5'd2, "st");
        chk(c_E_BT3, "st_t3");
        chk(c_E_CT4, "st_t4");
        chk(c_E_MT5, "st_t5");
        mem_done = 1'b1;
        chk(c_E_ST6, "st_t6");
        mem_done = 1'b0;
        chk(c_E_ST7, "st_t7_wait");
        mem_done = 1'b1;
        chk(c_E_ST7, "st_t7_done");

        // reset in the middle of an LD data wait
        fetch(5'd0, "ldr");
        chk(c_E_BT3, "ldr_t3");
        chk(c_E_CT4, "ldr_t4");
        chk(c_E_MT5, "ldr_t5");
        mem_done = 1'b0;
        chk(c_E_LD6, "ldr_t6_wait");
        reset = 1'b1;
        chk(c_E_LD6, "ldr_t6_reset_edge");
        reset = 1'b0;
        chk(c_E_IDLE, "ldr_after_reset");

        // undefined opcode pulses illegal for T3 only
        fetch(5'd31, "undef");
        chk(c_RUN | c_ILL, "undef_t3");

        // remaining ALU ops, ldi and nop
        fetch(5'd4, "sub");
        chk(c_E_RT3, "sub_t3");
        chk(c_E_RT4 | c_SUB, "sub_t4");
        chk(c_E_WB, "sub_t5");
        fetch(5'd5, "and");
        chk(c_E_RT3, "and_t3");
        chk(c_E_RT4 | c_AND, "and_t4");
        chk(c_E_WB, "and_t5");
        fetch(5'd6, "or");
        chk(c_E_RT3, "or_t3");
        chk(c_E_RT4 | c_OR, "or_t4");
        chk(c_E_WB, "or_t5");
        fetch(5'd1, "ldi");
        chk(c_E_BT3, "ldi_t3");
        chk(c_E_CT4, "ldi_t4");
        chk(c_E_WB, "ldi_t5");
        fetch(5'd26, "nop");
        chk(c_RUN, "nop_t3");

        // stop raised mid-instruction: add retires, then HALT
        fetch(5'd3, "add");
        chk(c_E_RT3, "add_t3");
        stop = 1'b1;
        chk(c_E_RT4 | c_ADD, "add_t4_stop");
        chk(c_E_WB, "add_t5_stop");
        stop = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            mem_done = i[1];
            chk(c_E_IDLE, "halt_idle");
        end
        step = 1'b0;

        // halt opcode, reached after leaving HALT through reset
        reset = 1'b1;
        chk(c_E_IDLE, "halt_reset");
        reset = 1'b0;
        chk(c_E_IDLE, "halt_reset_exit");
        fetch(5'd27, "hlt");
        chk(c_RUN, "hlt_t3");
        for (int i = 0; i < 3; i++) begin
            chk(c_E_IDLE, "hlt_stay");
        end

        @(posedge clk);
        #1;
        n_total++;
        if (q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL queue_drain: got %0d pending required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
